serial_alu_core: RTL and testbench
==================================

Name: serial_alu_core

Overview:
Parametrised, digit-serial ALU engine that is the next-generation datapath for the tt_um_cpu_top bit-serial CPU. It processes operands LSB-first, DIGIT bits per clock, instead of being fixed at 1 bit per clock. It supports configurable word width, a start/busy/done handshake, carry-in, and a full NZCV flag set. It sits between the CPU sequencer and the register file, and is driven in parallel from latched operand registers.

Parameters:
WIDTH, 8, operand/result word width in bits; min 2; must be a multiple of DIGIT.
DIGIT, 1, bits processed per clock; legal values 1, 2, 4; N = WIDTH/DIGIT digit cycles per operation.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  reset; asynchronous, active-low.
ena  input  1  global enable (TT ena); when low, all state is frozen.
start  input  1  request an operation; sampled only in IDLE with ena=1.
op  input  3  opcode, latched at accepted start.
a  input  WIDTH  operand A, latched at accepted start.
b  input  WIDTH  operand B, latched at accepted start.
cin  input  1  carry-in for ADC, latched at accepted start.
busy  output  1  high while an operation runs.
done  output  1  single-cycle completion pulse.
result  output  WIDTH  last written result; holds its value between operations.
flag_n, flag_z, flag_c, flag_v  output  1 each  flags of the last completed operation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, result, and all flags go to 0 immediately. An operation in progress is abandoned and no done is issued for it.
- FSM has two states, IDLE and RUN. Digit counter is ceil(log2 N) bits wide.
- IDLE -> RUN: on an edge with start=1 and ena=1. At that edge, op, a, b, and cin are latched into shift registers, the counter is cleared, carry is seeded, and busy is set.
- Carry seed: ADD=0, ADC=cin, SUB/CMP=1; for SUB/CMP, B is inverted per digit.
- RUN: each edge with ena=1 does the following:
  - consumes the low DIGIT bits of A and B and shifts the partial result in from the top;
  - updates the running carry;
  - ORs the digit into a zero-tracker;
  - increments the counter.
- RUN -> IDLE: at the edge that processes digit N-1. At that edge busy drops, done=1 for exactly one cycle, and result and flags update.
- Latency: done is high N cycles after busy rises.
- ena=0: nothing advances, done is held at 0, start is ignored, and latency stretches 1:1.
- start while busy is ignored (no queueing). start in the cycle where done=1 is accepted, since the FSM is then in IDLE.
- Opcodes:
  - 0 ADD, 1 ADC, 2 SUB (A-B), 3 CMP (A-B, flags only, result unchanged).
  - 4 AND, 5 OR, 6 XOR.
  - 7 per Optional Feature.
- Flags:
  - N = result MSB.
  - Z = all WIDTH result bits are zero.
  - C = carry-out of the MSB; for SUB/CMP this is the ARM-style not-borrow.
  - V = signed overflow, (a_msb==b'_msb) && (r_msb!=a_msb), where b' is the inverted B for SUB/CMP.
  - Logic ops set C=0 and V=0.
- All arithmetic is modulo 2^WIDTH; there is no saturation.

Optional Feature:
- Macro: SERIAL_ALU_SHL_EN.
- Defined: op 7 = SHL1. Result = {a[WIDTH-2:0],0}, C = a[WIDTH-1], V=0, N and Z from the result. Implemented serially with a one-bit delay stage between digits.
- Undefined: op 7 = PASS_B. Result = b, C=0, V=0, N and Z from the result.

Decomposition:
- Shared package/include serial_alu_pkg holds:
  - opcode constants OP_ADD..OP_OP7;
  - FSM state encodings S_IDLE and S_RUN;
  - the flag bit-index constants.
- One sub-module: serial_alu_digit, a combinational DIGIT-bit slice.
  - Inputs: a_d, b_d, carry_in, op.
  - Outputs: r_d, carry_out, and the MSB-carry needed for V.
  - Instantiated once; the core wraps the FSM, counter, and shift registers around it.

Test Plan:
1. WIDTH=8, DIGIT=1: ADD a=0x7F b=0x01 -> result=0x80, N=1 Z=0 C=0 V=1; done exactly 8 cycles after busy rises, 1 cycle wide.
2. SUB a=0x05 b=0x05 -> result=0x00, Z=1 C=1 V=0. Then CMP a=0x03 b=0x05 -> result stays 0x00, N=1 C=0 Z=0.
3. WIDTH=8, DIGIT=4: ADC a=0xFF b=0x00 cin=1 -> result=0x00, C=1 Z=1; done 2 cycles after busy. WIDTH=16, DIGIT=2: XOR 0xA5A5^0xFFFF -> 0x5A5A, C=0 V=0, latency 8.
4. start pulsed during busy (new a=0x11) is ignored and the first result is unchanged. ena held low for 3 cycles mid-RUN gives latency 8+3=11. Back-to-back start in the done cycle is accepted.
5. rst_n asserted asynchronously mid-RUN (between edges) -> busy, done, result, and flags go to 0 immediately; after release, no done appears until a new start.
6. op=7, a=0x81, b=0x5A:
   - with SERIAL_ALU_SHL_EN -> result=0x02, C=1, Z=0;
   - without -> result=0x5A, C=0, N=0.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: opcodes, FSM states, flag indices for serial_alu_core.
// Optional op 7 behaviour selected by SERIAL_ALU_SHL_EN.
package serial_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_CMP = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_OP7 = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Initial carry for digit 0; SUB/CMP add ~B+1.
  function automatic logic carry_seed(
    input logic [2:0] op,
    input logic       cin
  );
    case (op)
      OP_ADC:         return cin;
      OP_SUB, OP_CMP: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serial_alu_core_if.sv
// serial_alu_core_if: start/busy/done handshake and operand/result bus.
// master drives the request side, slave is the ALU core.
interface serial_alu_core_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output ena, start, op, a, b, cin,
    input  busy, done, result,
    input  flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  ena, start, op, a, b, cin,
    output busy, done, result,
    output flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/serial_alu_digit.sv
// serial_alu_digit: combinational DIGIT-bit ALU slice.
// SERIAL_ALU_SHL_EN turns op 7 into SHL1 (carry_in is the delayed bit).
module serial_alu_digit
  import serial_alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             carry_in,
  input  logic [2:0]       op,
  output logic [DIGIT-1:0] r_d,
  output logic             carry_out,
  output logic             msb_carry
);

  logic             sub;
  logic [DIGIT-1:0] b_x;
  logic [DIGIT:0]   sum;

  assign sub = (op == OP_SUB) || (op == OP_CMP);
  assign b_x = sub ? ~b_d : b_d;
  assign sum = {1'b0, a_d} + {1'b0, b_x}
             + {{DIGIT{1'b0}}, carry_in};

`ifdef SERIAL_ALU_SHL_EN
  logic [DIGIT:0] shl;
  assign shl = {a_d, carry_in};
`endif

  // Per-op digit result, carry out and carry into the digit MSB.
  always_comb begin
    r_d       = '0;
    carry_out = 1'b0;
    msb_carry = 1'b0;
    unique case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_CMP: begin
        r_d       = sum[DIGIT-1:0];
        carry_out = sum[DIGIT];
        msb_carry = a_d[DIGIT-1] ^ b_x[DIGIT-1]
                  ^ sum[DIGIT-1];
      end
      OP_AND: r_d = a_d & b_d;
      OP_OR:  r_d = a_d | b_d;
      OP_XOR: r_d = a_d ^ b_d;
      OP_OP7: begin
`ifdef SERIAL_ALU_SHL_EN
        r_d       = shl[DIGIT-1:0];
        carry_out = shl[DIGIT];
`else
        r_d = b_d;
`endif
      end
      default: r_d = '0;
    endcase
  end

endmodule

// File: rtl/serial_alu_core.sv
// serial_alu_core: digit-serial ALU, LSB first, DIGIT bits per clock.
// Macro SERIAL_ALU_SHL_EN selects SHL1 for op 7 (else PASS_B).
module serial_alu_core
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic               clk,
  input logic               rst_n,
  serial_alu_core_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             nz_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       flags_q;

  logic [DIGIT-1:0]       r_d;
  logic                   c_out;
  logic                   c_msb;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       acc_d;
  logic [3:0]             flags_d;
  logic                   last;
  logic                   arith;

  serial_alu_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a_d       (a_q[DIGIT-1:0]),
    .b_d       (b_q[DIGIT-1:0]),
    .carry_in  (carry_q),
    .op        (op_q),
    .r_d       (r_d),
    .carry_out (c_out),
    .msb_carry (c_msb)
  );

  assign cat   = {r_d, acc_q};
  assign acc_d = cat[WIDTH+DIGIT-1:DIGIT];
  assign last  = (cnt_q == LAST);
  assign arith = (op_q <= OP_CMP);

  // Flags as they stand once the final digit is folded in.
  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_N] = acc_d[WIDTH-1];
    flags_d[FLAG_Z] = ~(nz_q | (|r_d));
    flags_d[FLAG_C] = c_out;
    flags_d[FLAG_V] = arith & (c_out ^ c_msb);
  end

  // IDLE/RUN sequencer with operand shifters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      nz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.ena) begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              op_q    <= bus.op;
              a_q     <= bus.a;
              b_q     <= bus.b;
              carry_q <= carry_seed(bus.op, bus.cin);
              cnt_q   <= '0;
              nz_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
          end
          S_RUN: begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            acc_q   <= acc_d;
            carry_q <= c_out;
            nz_q    <= nz_q | (|r_d);
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              flags_q <= flags_d;
              if (op_q != OP_CMP) begin
                result_q <= acc_d;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flag_n = flags_q[FLAG_N];
  assign bus.flag_z = flags_q[FLAG_Z];
  assign bus.flag_c = flags_q[FLAG_C];
  assign bus.flag_v = flags_q[FLAG_V];

endmodule

// File: tb/tb_serial_alu_core.sv
// tb_serial_alu_core: three core configs vs an arithmetic reference model.
// Honours SERIAL_ALU_SHL_EN for the op 7 expectations.
module tb_serial_alu_core;
  import serial_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [2:0]  start_v;
  logic [2:0]  opv;
  logic [15:0] av;
  logic [15:0] bv;
  logic        cinv;
  logic [2:0]  done_v;
  logic [2:0]  busy_v;
  logic [15:0] prev [3];
  int          checks;
  int          errors;

  serial_alu_core_if #(.WIDTH(8))  if0 ();
  serial_alu_core_if #(.WIDTH(8))  if1 ();
  serial_alu_core_if #(.WIDTH(16)) if2 ();

  serial_alu_core #(.WIDTH(8), .DIGIT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  serial_alu_core #(.WIDTH(8), .DIGIT(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  serial_alu_core #(.WIDTH(16), .DIGIT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  assign if0.ena = ena;
  assign if1.ena = ena;
  assign if2.ena = ena;
  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if0.op = opv;
  assign if1.op = opv;
  assign if2.op = opv;
  assign if0.a = av[7:0];
  assign if1.a = av[7:0];
  assign if2.a = av;
  assign if0.b = bv[7:0];
  assign if1.b = bv[7:0];
  assign if2.b = bv;
  assign if0.cin = cinv;
  assign if1.cin = cinv;
  assign if2.cin = cinv;
  assign done_v = {if2.done, if1.done, if0.done};
  assign busy_v = {if2.busy, if1.busy, if0.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] obs(input int sel);
    case (sel)
      0: return {8'h00, if0.result, if0.flag_n,
                 if0.flag_z, if0.flag_c, if0.flag_v};
      1: return {8'h00, if1.result, if1.flag_n,
                 if1.flag_z, if1.flag_c, if1.flag_v};
      default: return {if2.result, if2.flag_n,
                       if2.flag_z, if2.flag_c, if2.flag_v};
    endcase
  endfunction

  // Reference: {result, N, Z, C, V} by plain integer arithmetic.
  function automatic logic [19:0] model(
    input logic [2:0] o, input logic [15:0] x16,
    input logic [15:0] y16, input logic ci,
    input logic [15:0] pr, input int w
  );
    int m, hi, x, y, bb, s;
    logic [15:0] r;
    logic n, z, c, v;
    m  = (1 << w) - 1;
    hi = 1 << (w - 1);
    x  = int'(x16) & m;
    y  = int'(y16) & m;
    bb = y;
    c  = 1'b0;
    v  = 1'b0;
    s  = 0;
    case (o)
      3'd0: s = x + y;
      3'd1: s = x + y + int'(ci);
      3'd2, 3'd3: begin
        bb = ~y & m;
        s  = x + bb + 1;
      end
      3'd4: s = x & y;
      3'd5: s = x | y;
      3'd6: s = x ^ y;
      default: begin
`ifdef SERIAL_ALU_SHL_EN
        s = x << 1;
        c = (x & hi) != 0;
`else
        s = y;
`endif
      end
    endcase
    r = 16'(s & m);
    if (o <= 3'd3) begin
      c = ((s >> w) & 1) != 0;
      v = ((x & hi) == (bb & hi)) &&
          ((int'(r) & hi) != (x & hi));
    end
    n = (int'(r) & hi) != 0;
    z = (r == 16'h0);
    if (o == 3'd3) r = pr;
    return {r, n, z, c, v};
  endfunction

  // Issue one op on instance sel; returns cycles from busy to done.
  task automatic go(
    input int sel, input logic [2:0] o,
    input logic [15:0] x, input logic [15:0] y,
    input logic ci, output int lat, output logic bz
  );
    opv = o; av = x; bv = y; cinv = ci;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    bz  = busy_v[sel];
    lat = 0;
    while (!done_v[sel] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; start_v = '0;
    opv = '0; av = '0; bv = '0; cinv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (obs(s) !== 20'h0) begin
        errors++;
        $display("FAIL reset_out[%0d] got %h exp 0", s, obs(s));
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy_v, done_v} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hs got %b exp 0", {busy_v, done_v});
    end
    for (int s = 0; s < 3; s++) prev[s] = '0;
  endtask

  task automatic test_add_latency();
    int lat; logic bz;
    go(0, OP_ADD, 16'h7F, 16'h01, 1'b0, lat, bz);
    checks++;
    if (obs(0) !== {16'h0080, 4'b1001}) begin
      errors++;
      $display("FAIL add got %h exp %h", obs(0), {16'h0080, 4'b1001});
    end
    checks++;
    if (lat !== 8 || bz !== 1'b1) begin
      errors++;
      $display("FAIL add_lat got %0d/%b exp 8/1", lat, bz);
    end
    @(posedge clk); #1;
    checks++;
    if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL done_width got done=%b busy=%b exp 0/0",
               done_v[0], busy_v[0]);
    end
    prev[0] = 16'h0080;
  endtask

  task automatic test_sub_cmp();
    int lat; logic bz;
    go(0, OP_SUB, 16'h05, 16'h05, 1'b0, lat, bz);
    checks++;
    if (obs(0) !== {16'h0000, 4'b0110}) begin
      errors++;
      $display("FAIL sub got %h exp %h", obs(0), {16'h0000, 4'b0110});
    end
    go(0, OP_CMP, 16'h03, 16'h05, 1'b0, lat, bz);
    checks++;
    if (obs(0) !== {16'h0000, 4'b1000}) begin
      errors++;
      $display("FAIL cmp got %h exp %h", obs(0), {16'h0000, 4'b1000});
    end
    prev[0] = 16'h0000;
  endtask

  task automatic test_op7();
    int lat; logic [19:0] exp_v; logic bz;
`ifdef SERIAL_ALU_SHL_EN
    exp_v = {16'h0002, 4'b0010};
`else
    exp_v = {16'h005A, 4'b0000};
`endif
    go(0, OP_OP7, 16'h81, 16'h5A, 1'b0, lat, bz);
    checks++;
    if (obs(0) !== exp_v) begin
      errors++;
      $display("FAIL op7 got %h exp %h", obs(0), exp_v);
    end
    prev[0] = exp_v[19:4];
  endtask

  task automatic test_busy_start();
    int lat;
    opv = OP_ADD; av = 16'h20; bv = 16'h03; cinv = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    opv = OP_XOR; av = 16'h11; start_v[0] = 1'b1;
    @(posedge clk); #1; lat++;
    start_v[0] = 1'b0;
    while (!done_v[0] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (obs(0) !== {16'h0023, 4'b0000} || lat !== 8) begin
      errors++;
      $display("FAIL busy_start got %h lat %0d exp %h lat 8",
               obs(0), lat, {16'h0023, 4'b0000});
    end
    @(posedge clk); #1;
    checks++;
    if (busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_queued got busy=%b exp 0", busy_v[0]);
    end
    prev[0] = 16'h0023;
  endtask

  task automatic test_ena_stall();
    int lat; logic bad;
    bad = 1'b0;
    opv = OP_SUB; av = 16'h10; bv = 16'h20; cinv = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    ena = 1'b0;
    repeat (3) begin
      @(posedge clk); #1; lat++;
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1) bad = 1'b1;
    end
    ena = 1'b1;
    while (!done_v[0] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 11 || bad) begin
      errors++;
      $display("FAIL ena_stall got lat %0d hold_bad %b exp 11/0",
               lat, bad);
    end
    checks++;
    if (obs(0) !== {16'h00F0, 4'b1000}) begin
      errors++;
      $display("FAIL ena_stall_res got %h exp %h",
               obs(0), {16'h00F0, 4'b1000});
    end
    prev[0] = 16'h00F0;
  endtask

  task automatic test_back_to_back();
    int lat; logic bz; logic [19:0] e;
    go(0, OP_ADD, 16'hC0, 16'h50, 1'b0, lat, bz);
    go(0, OP_AND, 16'h3C, 16'hF5, 1'b0, lat, bz);
    e = model(OP_AND, 16'h3C, 16'hF5, 1'b0, prev[0], 8);
    checks++;
    if (obs(0) !== e || lat !== 8) begin
      errors++;
      $display("FAIL back_to_back got %h lat %0d exp %h lat 8",
               obs(0), lat, e);
    end
    prev[0] = e[19:4];
  endtask

  task automatic test_random(input int sel, input int w,
                             input int elat, input int iters);
    int lat; logic bz; logic [19:0] e;
    logic [2:0] o; logic [15:0] x, y; logic ci;
    for (int i = 0; i < iters; i++) begin
      o  = 3'($urandom_range(0, 7));
      x  = 16'($urandom) & 16'((1 << w) - 1);
      y  = 16'($urandom) & 16'((1 << w) - 1);
      ci = 1'($urandom_range(0, 1));
      go(sel, o, x, y, ci, lat, bz);
      e = model(o, x, y, ci, prev[sel], w);
      checks++;
      if (obs(sel) !== e || lat !== elat) begin
        errors++;
        $display("FAIL rand%0d op%0d a=%h b=%h c=%b got %h/%0d exp %h/%0d",
                 sel, o, x, y, ci, obs(sel), lat, e, elat);
      end
      prev[sel] = e[19:4];
    end
  endtask

  task automatic test_digit4();
    int lat; logic bz;
    go(1, OP_ADC, 16'hFF, 16'h00, 1'b1, lat, bz);
    checks++;
    if (obs(1) !== {16'h0000, 4'b0110} || lat !== 2) begin
      errors++;
      $display("FAIL adc_d4 got %h lat %0d exp %h lat 2",
               obs(1), lat, {16'h0000, 4'b0110});
    end
    prev[1] = 16'h0000;
  endtask

  task automatic test_width16();
    int lat; logic bz;
    go(2, OP_XOR, 16'hA5A5, 16'hFFFF, 1'b0, lat, bz);
    checks++;
    if (obs(2) !== {16'h5A5A, 4'b0000} || lat !== 8) begin
      errors++;
      $display("FAIL xor_w16 got %h lat %0d exp %h lat 8",
               obs(2), lat, {16'h5A5A, 4'b0000});
    end
    prev[2] = 16'h5A5A;
  endtask

  task automatic test_async_reset();
    int lat; logic bz; logic seen;
    go(0, OP_OR, 16'hF0, 16'h0F, 1'b0, lat, bz);
    opv = OP_ADD; av = 16'h12; bv = 16'h34; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs(0) !== 20'h0 || busy_v[0] !== 1'b0
        || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got %h busy %b done %b exp 0",
               obs(0), busy_v[0], done_v[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | done_v[0] | busy_v[0];
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_abandon got done/busy seen=%b exp 0",
               seen);
    end
    for (int s = 0; s < 3; s++) prev[s] = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_latency();
    test_sub_cmp();
    test_op7();
    test_busy_start();
    test_ena_stall();
    test_back_to_back();
    test_random(0, 8, 8, 40);
    test_digit4();
    test_random(1, 8, 2, 20);
    test_width16();
    test_random(2, 16, 8, 20);
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
